multicycle_control_fsm: RTL and testbench

// - Moore control sequencer for the multicycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut regs.
// - Decodes Op/Funct from the IR and steps each instruction through FETCH..WRITEBACK, one state per clk.
// - Drives every mux select, write enable and ALU function of the datapath; replaces the single-cycle ControlUnit.

---
 rtl/multicycle_control_fsm_if.sv | 38 +++
 rtl/multicycle_control_fsm.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
//   master : the control FSM (reads Op/Funct/Zero, drives selects and enables)
//   slave  : the datapath (drives Op/Funct/Zero, consumes selects and enables)
// Signals:
//   Op, Funct   IR[31:26] / IR[5:0]
//   Zero        ALU zero flag of the current cycle
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
//   ALUControl, PCSrc, PCEn   datapath controls
//   State       current sequencer state, for debug
interface multicycle_control_fsm_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, PCEn, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, PCEn, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle MIPS datapath. Steps each
// instruction through FETCH..WRITEBACK, one state per clock, and decodes all
// datapath selects, write enables and the ALU function from the state.
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   bus         control bundle (master side), see multicycle_control_fsm_if
//   InstrCount  retired-instruction count, only when MC_INSTR_COUNT_EN is defined
// Build option:
//   MC_INSTR_COUNT_EN  adds the CNT_W-bit retired-instruction counter
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
`ifdef MC_INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0]         InstrCount
`endif
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;
    localparam logic [2:0] AluNor = 3'b100;

    state_e state_q, state_d;
    // lw/sw distinction is captured in DECODE so MEMADR need not look at Op.
    logic   is_store_q, is_store_d;
    logic   pc_write, branch;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = StFetch;
        is_store_d = is_store_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                is_store_d = (bus.Op == OpSw);
                case (bus.Op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = is_store_q ? StMemWr : StMemRd;
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StFetch;  // writebacks, branch, jump, unused codes
        endcase
    end

    // Output decode
    always_comb begin
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = AluAnd;
        bus.PCSrc      = 2'b00;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state_q)
            StFetch: begin
                bus.IRWrite    = 1'b1;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = AluAdd;
                pc_write       = 1'b1;
            end
            StDecode: begin
                bus.ALUSrcB    = 2'b11;
                bus.ALUControl = AluAdd;
            end
            StMemAdr, StAddiEx: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = AluAdd;
            end
            StMemRd: bus.IorD = 1'b1;
            StMemWb: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            StMemWr: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            StExec: begin
                bus.ALUSrcA = 1'b1;
                case (bus.Funct)
                    6'b100010: bus.ALUControl = AluSub;
                    6'b100100: bus.ALUControl = AluAnd;
                    6'b100101: bus.ALUControl = AluOr;
                    6'b101010: bus.ALUControl = AluSlt;
                    6'b100111: bus.ALUControl = AluNor;
                    default:   bus.ALUControl = AluAdd;
                endcase
            end
            StAluWb: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = (bus.Funct != 6'b000000);  // NOP writes nothing
            end
            StBranch: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = AluSub;
                bus.PCSrc      = 2'b01;
                branch         = 1'b1;
            end
            StAddiWb: bus.RegWrite = 1'b1;
            StJump: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase

        bus.PCEn = (pc_write | (branch & bus.Zero)) & ~reset;
        // Reset suppresses every architectural write so an abandoned
        // instruction leaves no partial effect.
        if (reset) begin
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
            bus.IRWrite  = 1'b0;
        end
    end

    assign bus.State = state_q;

`ifdef MC_INSTR_COUNT_EN
    logic [CNT_W-1:0] instr_count_q;
    logic             retire;

    // Every state that finishes a real instruction; DECODE->FETCH is excluded.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            StMemWb, StMemWr, StAluWb, StBranch, StAddiWb, StJump: retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q <= '0;
        end else if (retire) begin
            instr_count_q <= instr_count_q + CNT_W'(1);
        end
    end

    assign InstrCount = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic reset;
    multicycle_control_fsm_if bus_if ();
`ifdef MC_INSTR_COUNT_EN
    logic [CNT_W-1:0] instr_count;
`endif

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
`ifdef MC_INSTR_COUNT_EN
        ,
        .InstrCount (instr_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] model_count;
    int seq[$];

    int       obs_cycles;
    logic [3:0] obs_last_state;
    logic     obs_last_rw, obs_last_mw, obs_last_pcen;
    logic [2:0] obs_alu3;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        int         cpi;
        logic [3:0] last_state;
        logic       last_rw;
        logic       last_mw;
        logic       last_pcen;
        logic [2:0] alu3;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_valid(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    // Expected state walk of one instruction, from its FETCH to its last state.
    function automatic void fill_seq(input logic [5:0] op);
        seq = {};
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            6'b100011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            6'b101011: begin seq.push_back(2); seq.push_back(5); end
            6'b000000: begin seq.push_back(6); seq.push_back(7); end
            6'b000100: seq.push_back(8);
            6'b001000: begin seq.push_back(9); seq.push_back(10); end
            6'b000010: seq.push_back(11);
            default: ;
        endcase
    endfunction

    function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            6'b100111: return 3'b100;
            default:   return 3'b010;
        endcase
    endfunction

    // Control word {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUControl,PCSrc,PCEn}
    function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] f, input logic z);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0, pcen = 0;
        logic [1:0] asb = 0, pcs = 0;
        logic [2:0] alu = 0;
        case (st)
            0:  begin irw = 1; asb = 2'b01; alu = 3'b010; pcen = 1; end
            1:  begin asb = 2'b11; alu = 3'b010; end
            2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; alu = alu_for_funct(f); end
            7:  begin rd = 1; rw = (f != 6'd0); end
            8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
            9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {iord, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pcen};
    endfunction

    function automatic logic [14:0] obs_ctrl();
        return {bus_if.IorD, bus_if.MemWrite, bus_if.IRWrite, bus_if.RegDst, bus_if.MemtoReg,
                bus_if.RegWrite, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ALUControl,
                bus_if.PCSrc, bus_if.PCEn};
    endfunction

    // Runs one instruction starting in FETCH; leaves the DUT back in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
        fill_seq(op);
        bus_if.Op = op;
        bus_if.Funct = f;
        bus_if.Zero = z;
        #1;
        obs_cycles = 0;
        obs_alu3 = 3'b000;
        for (int k = 0; k < 10; k++) begin
            if (k < seq.size()) begin
                check("state", 32'(bus_if.State), 32'(seq[k]));
                check("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(seq[k], f, z)));
            end
            obs_last_state = bus_if.State;
            obs_last_rw = bus_if.RegWrite;
            obs_last_mw = bus_if.MemWrite;
            obs_last_pcen = bus_if.PCEn;
            if (k == 2) obs_alu3 = bus_if.ALUControl;
            obs_cycles = k + 1;
            step();
            if (bus_if.State == 4'd0) break;
        end
        check("cycles", 32'(obs_cycles), 32'(seq.size()));
        if (is_valid(op)) model_count = model_count + 1;
`ifdef MC_INSTR_COUNT_EN
        check("instr_count", 32'(instr_count), 32'(model_count));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] functs[7];
        logic [5:0] op, f;

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};

        // op, funct, zero, cpi, last state, last RegWrite, last MemWrite, last PCEn, ALU in 3rd cycle
        vecs.push_back('{6'b100011, 6'b000000, 1'b0, 5, 4'd4, 1'b1, 1'b0, 1'b0, 3'b010});
        vecs.push_back('{6'b101011, 6'b000000, 1'b0, 4, 4'd5, 1'b0, 1'b1, 1'b0, 3'b010});
        vecs.push_back('{6'b000000, 6'b100000, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 3'b010});
        vecs.push_back('{6'b000000, 6'b100010, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 3'b110});
        vecs.push_back('{6'b000000, 6'b100100, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 3'b000});
        vecs.push_back('{6'b000000, 6'b100101, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 3'b001});
        vecs.push_back('{6'b000000, 6'b101010, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 3'b111});
        vecs.push_back('{6'b000000, 6'b100111, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 3'b100});
        vecs.push_back('{6'b000000, 6'b111111, 1'b0, 4, 4'd7, 1'b1, 1'b0, 1'b0, 3'b010});
        vecs.push_back('{6'b000000, 6'b000000, 1'b0, 4, 4'd7, 1'b0, 1'b0, 1'b0, 3'b010});
        vecs.push_back('{6'b000100, 6'b000000, 1'b1, 3, 4'd8, 1'b0, 1'b0, 1'b1, 3'b110});
        vecs.push_back('{6'b000100, 6'b000000, 1'b0, 3, 4'd8, 1'b0, 1'b0, 1'b0, 3'b110});
        vecs.push_back('{6'b001000, 6'b000000, 1'b0, 4, 4'd10, 1'b1, 1'b0, 1'b0, 3'b010});
        vecs.push_back('{6'b000010, 6'b000000, 1'b0, 3, 4'd11, 1'b0, 1'b0, 1'b1, 3'b000});
        vecs.push_back('{6'b111111, 6'b000000, 1'b0, 2, 4'd1, 1'b0, 1'b0, 1'b0, 3'b000});

        // Reset: writes are masked even though the state decodes as FETCH.
        reset = 1'b1;
        bus_if.Op = 6'd0;
        bus_if.Funct = 6'd0;
        bus_if.Zero = 1'b0;
        model_count = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_state", 32'(bus_if.State), 32'd0);
            check("rst_regwrite", 32'(bus_if.RegWrite), 32'd0);
            check("rst_memwrite", 32'(bus_if.MemWrite), 32'd0);
            check("rst_irwrite", 32'(bus_if.IRWrite), 32'd0);
            check("rst_pcen", 32'(bus_if.PCEn), 32'd0);
            check("rst_alusrcb", 32'(bus_if.ALUSrcB), 32'd1);
        end
        reset = 1'b0;
        #1;
        check("post_rst_state", 32'(bus_if.State), 32'd0);
        check("post_rst_irwrite", 32'(bus_if.IRWrite), 32'd1);
        check("post_rst_pcen", 32'(bus_if.PCEn), 32'd1);
        check("post_rst_alusrcb", 32'(bus_if.ALUSrcB), 32'd1);
        check("post_rst_alu", 32'(bus_if.ALUControl), 32'd2);
`ifdef MC_INSTR_COUNT_EN
        check("post_rst_count", 32'(instr_count), 32'd0);
`endif

        // Table-driven instructions
        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].funct, vecs[i].z);
            check("tbl_cpi", 32'(obs_cycles), 32'(vecs[i].cpi));
            check("tbl_last_state", 32'(obs_last_state), 32'(vecs[i].last_state));
            check("tbl_last_regwrite", 32'(obs_last_rw), 32'(vecs[i].last_rw));
            check("tbl_last_memwrite", 32'(obs_last_mw), 32'(vecs[i].last_mw));
            check("tbl_last_pcen", 32'(obs_last_pcen), 32'(vecs[i].last_pcen));
            check("tbl_alu3", 32'(obs_alu3), 32'(vecs[i].alu3));
        end

        // sw abandoned by reset in MEMWR
        bus_if.Op = 6'b101011;
        #1;
        for (int i = 0; i < 3; i++) step();
        check("sw_in_memwr", 32'(bus_if.State), 32'd5);
        reset = 1'b1;
        #1;
        check("sw_rst_memwrite", 32'(bus_if.MemWrite), 32'd0);
        check("sw_rst_iord", 32'(bus_if.IorD), 32'd1);
        step();
        check("sw_rst_state", 32'(bus_if.State), 32'd0);
        reset = 1'b0;
        model_count = '0;
        #1;
`ifdef MC_INSTR_COUNT_EN
        check("sw_rst_count", 32'(instr_count), 32'd0);
`endif

        // R-type abandoned by reset in ALUWB
        bus_if.Op = 6'b000000;
        bus_if.Funct = 6'b100000;
        #1;
        for (int i = 0; i < 3; i++) step();
        check("r_in_aluwb", 32'(bus_if.State), 32'd7);
        reset = 1'b1;
        #1;
        check("r_rst_regwrite", 32'(bus_if.RegWrite), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("r_rst_state", 32'(bus_if.State), 32'd0);

        // Illegal opcode does not retire; lw, j, addi do.
        run_instr(6'b111111, 6'd0, 1'b0);
        run_instr(6'b100011, 6'd0, 1'b0);
        run_instr(6'b000010, 6'd0, 1'b0);
        run_instr(6'b001000, 6'd0, 1'b0);
`ifdef MC_INSTR_COUNT_EN
        check("count_after_three", 32'(instr_count), 32'd3);
`endif

        // Randomized instruction stream against the model
        for (int n = 0; n < 300; n++) begin
            int pick;
            pick = int'($urandom_range(0, 7));
            if (pick < 6) op = ops[pick];
            else op = 6'($urandom);
            if ($urandom_range(0, 1) == 0) f = functs[$urandom_range(0, 6)];
            else f = 6'($urandom);
            run_instr(op, f, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
